lzc_pipe: RTL and testbench
===========================

// Module: lzc_pipe
// PURPOSE
//  Pipelined, multi-lane leading/trailing bit counter with valid/ready flow control.
//  Per lane: counts leading or trailing zeros or ones; flags an all-target word; emits the word normalised by the count.
//  Feeds FP normalisation, priority-encode and arbitration paths where the combinational count path is too long.
// PARAMETERS
//  IN_WIDTH  32  bits per lane; >=4; need not be a power of two
//  LANES     1   independent lanes, all sharing one handshake
//  STAGES    2   pipeline depth = latency in cycles; legal 1..3
// PORTS
//  clk        in   1                  clock; all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  block can accept a beat this cycle
//  in_data    in   LANES*IN_WIDTH     lane k = in_data[k*IN_WIDTH +: IN_WIDTH]
//  in_mode    in   2                  [1]: 0=leading, 1=trailing; [0]: 0=count zeros, 1=count ones
//  out_valid  out  1                  result beat valid
//  out_ready  in   1                  downstream accepts the result
//  out_count  out  LANES*CNT_W        CNT_W = $clog2(IN_WIDTH+1); per-lane count
//  out_all    out  LANES              lane word is entirely the target bit (count==IN_WIDTH)
//  out_norm   out  LANES*IN_WIDTH     leading: in<<count; trailing: in>>count; zero fill
//  out_mode   out  2                  in_mode carried with the beat
// BEHAVIOUR
//  - Reset: every stage-valid bit = 0 on the cycle after rst is seen high, so out_valid=0. Data registers are not reset.
//  - With rst high: in_ready=0, and no beat is accepted.
//  - A beat is accepted when in_valid & in_ready.
//  - Global advance: adv = ~out_valid | out_ready, and in_ready = adv & ~rst. Every stage shifts when adv; all hold otherwise.
//  - Internal bubbles are filled: a stage whose valid=0 is overwritten on adv.
//  - Latency: a beat accepted at cycle t is presented at t+STAGES when no stall occurs.
//    With continuous adv, throughput is 1 beat/cycle.
//  - Stall: out_* stays stable while out_valid & ~out_ready. No beat is lost, duplicated or reordered.
//  - Count rule:
//    - Leading counts from bit IN_WIDTH-1 downward; trailing counts from bit 0 upward.
//    - The target bit is 0 (zeros) or 1 (ones). The count is the run length of the target bit before the first non-target bit.
//  - Non-power-of-two IN_WIDTH: the word is padded internally to P = 2**$clog2(IN_WIDTH). Pad bits carry the non-target value and sit beyond the scanned end, so count <= IN_WIDTH.
//  - out_all = (count == IN_WIDTH). In that case out_norm = 0.
//  - out_norm width is IN_WIDTH; bits shifted out are dropped.
//  - Stage 1 registers the mode-conditioned word: inverted for ones, bit-reversed for trailing. The final stage registers count, all and norm.
//  - Tree split points for STAGES=3 are free, provided latency is exact.
//  - Lanes never interact; every lane uses the same in_mode.
//  - Mid-operation reset drops all in-flight beats. The first beat accepted after rst falls produces the first out_valid.
// STRUCTURE
//  - lzc_pkg holds:
//    - lzc_mode_t, a 2-bit packed struct {dir, polarity};
//    - the enum constants LZC_LEADING, LZC_TRAILING, LZC_ZEROS, LZC_ONES;
//    - function cnt_w(int w) = $clog2(w+1).
//  - Sub-module lzc_core (combinational, one per lane, generate loop):
//    - padded pairwise-NOR tree count of leading zeros of a conditioned word;
//    - parametrised by IN_WIDTH.
//  - The top holds the conditioning logic, pipeline registers, handshake and normalising shifter.
// TESTING
//  1. IN_WIDTH=32, mode=leading/zeros, in=0x0001_0000 -> after 2 cycles: count=15, all=0, norm=0x8000_0000.
//  2. in=0x0000_0000, leading/zeros -> count=32, all=1, norm=0. Then in=0xFFFF_FFFF, leading/ones -> count=32, all=1.
//  3. IN_WIDTH=24: in=0x00_0001 leading/zeros -> count=23. Same word with trailing/zeros -> count=0, norm=0x00_0001.
//  4. LANES=2, trailing/ones, lanes={0x0000_00FF, 0x8000_0000} -> counts={8,0}; norm lane0=0x0000_0000.
//  5. Stream 8 beats back to back, with out_ready low for cycles 3..7 -> all 8 results in order, none dropped or repeated, out_* stable while stalled, in_ready low while full.
//  6. Pulse rst with 2 beats in flight -> out_valid=0 the next cycle, in_ready=0 during rst, in-flight beats never appear; the next beat completes normally.

Source files
------------

// File: rtl/lzc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzc_pkg : mode encoding and width helper shared by the lzc_pipe block
// Revision: 1.0
// ---------------------------------------------------------------------------
package lzc_pkg;

  typedef enum logic {
    LZC_LEADING  = 1'b0,
    LZC_TRAILING = 1'b1
  } lzc_dir_e;

  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_pol_e;

  typedef struct packed {
    lzc_dir_e dir;
    lzc_pol_e polarity;
  } lzc_mode_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzc_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzc_core : combinational leading-zero count of an already-conditioned word
// Revision: 1.0
// ---------------------------------------------------------------------------
module lzc_core
  import lzc_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  localparam int CNT_W = cnt_w(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] i_word,
  output logic [CNT_W-1:0]    o_cnt
);

  localparam int L = $clog2(IN_WIDTH);
  localparam int P = 1 << L;

  logic [P-1:0] w_pad;

  // Pad below the scanned end with ones so the count can never exceed IN_WIDTH.
  if (P > IN_WIDTH) begin : g_pad
    assign w_pad = {i_word, {(P - IN_WIDTH){1'b1}}};
  end else begin : g_nopad
    assign w_pad = i_word;
  end

  always_comb begin : p_tree
    logic           z [P];
    logic [L-1:0]   c [P];
    for (int i = 0; i < P; i++) begin
      z[i] = ~w_pad[P-1-i];
      c[i] = '0;
    end
    for (int lvl = 0; lvl < L; lvl++) begin
      for (int i = 0; i < P; i += (2 << lvl)) begin
        if (z[i]) c[i] = c[i + (1 << lvl)] | L'(1 << lvl);
        z[i] = z[i] & z[i + (1 << lvl)];
      end
    end
    o_cnt = z[0] ? CNT_W'(P) : CNT_W'(c[0]);
  end

endmodule
`default_nettype wire

// File: rtl/lzc_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzc_pipe : pipelined multi-lane leading/trailing zero/one counter, valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int LANES    = 1,
  parameter int STAGES   = 2,
  localparam int CNT_W = cnt_w(IN_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*CNT_W-1:0]    out_count,
  output logic [LANES-1:0]          out_all,
  output logic [LANES*IN_WIDTH-1:0] out_norm,
  output logic [1:0]                out_mode
);

  function automatic logic [IN_WIDTH-1:0] rev(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH-1:0] r;
    for (int i = 0; i < IN_WIDTH; i++) r[i] = d[IN_WIDTH-1-i];
    return r;
  endfunction

  // Map every mode onto "leading zeros" so a single core serves all four.
  function automatic logic [IN_WIDTH-1:0] cond(input logic [IN_WIDTH-1:0] d, input lzc_mode_t m);
    logic [IN_WIDTH-1:0] r;
    r = (m.dir == LZC_TRAILING) ? rev(d) : d;
    return (m.polarity == LZC_ONES) ? ~r : r;
  endfunction

  logic                      w_adv;
  logic                      w_accept;
  logic [STAGES-1:0]         r_vld;
  lzc_mode_t                 w_in_mode;
  lzc_mode_t                 w_core_mode;
  lzc_mode_t                 w_fin_mode;
  logic [LANES*IN_WIDTH-1:0] w_cond;
  logic [LANES*IN_WIDTH-1:0] w_core_word;
  logic [LANES*IN_WIDTH-1:0] w_fin_word;
  logic [LANES*IN_WIDTH-1:0] w_norm;
  logic [LANES*CNT_W-1:0]    w_core_cnt;
  logic [LANES*CNT_W-1:0]    w_fin_cnt;
  logic [LANES-1:0]          w_all;
  logic [LANES*CNT_W-1:0]    r_count;
  logic [LANES-1:0]          r_all;
  logic [LANES*IN_WIDTH-1:0] r_norm;
  lzc_mode_t                 r_mode;

  assign w_in_mode = lzc_mode_t'(in_mode);
  assign out_valid = r_vld[STAGES-1];
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv & ~rst;
  assign w_accept  = in_valid & in_ready;

  // The whole pipe moves in lockstep, so bubbles are overwritten as it shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= STAGES'({r_vld, w_accept});
    end
  end

  if (STAGES >= 2) begin : g_s1_reg
    logic [LANES*IN_WIDTH-1:0] r_s1_word;
    lzc_mode_t                 r_s1_mode;
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_s1_word <= w_cond;
        r_s1_mode <= w_in_mode;
      end
    end
    assign w_core_word = r_s1_word;
    assign w_core_mode = r_s1_mode;
  end else begin : g_s1_comb
    assign w_core_word = w_cond;
    assign w_core_mode = w_in_mode;
  end

  if (STAGES == 3) begin : g_s2_reg
    logic [LANES*IN_WIDTH-1:0] r_s2_word;
    logic [LANES*CNT_W-1:0]    r_s2_cnt;
    lzc_mode_t                 r_s2_mode;
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_s2_word <= w_core_word;
        r_s2_cnt  <= w_core_cnt;
        r_s2_mode <= w_core_mode;
      end
    end
    assign w_fin_word = r_s2_word;
    assign w_fin_cnt  = r_s2_cnt;
    assign w_fin_mode = r_s2_mode;
  end else begin : g_s2_comb
    assign w_fin_word = w_core_word;
    assign w_fin_cnt  = w_core_cnt;
    assign w_fin_mode = w_core_mode;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_WIDTH-1:0] w_plain;
    logic [IN_WIDTH-1:0] w_shl;
    logic [CNT_W-1:0]    w_cnt;

    assign w_cond[k*IN_WIDTH +: IN_WIDTH] = cond(in_data[k*IN_WIDTH +: IN_WIDTH], w_in_mode);

    lzc_core #(.IN_WIDTH(IN_WIDTH)) u_core (
      .i_word (w_core_word[k*IN_WIDTH +: IN_WIDTH]),
      .o_cnt  (w_core_cnt[k*CNT_W +: CNT_W])
    );

    // Undo the inversion only; a trailing shift is a left shift in reversed space.
    assign w_cnt   = w_fin_cnt[k*CNT_W +: CNT_W];
    assign w_plain = (w_fin_mode.polarity == LZC_ONES) ? ~w_fin_word[k*IN_WIDTH +: IN_WIDTH]
                                                       :  w_fin_word[k*IN_WIDTH +: IN_WIDTH];
    assign w_shl   = w_plain << w_cnt;
    assign w_norm[k*IN_WIDTH +: IN_WIDTH] = (w_fin_mode.dir == LZC_TRAILING) ? rev(w_shl) : w_shl;
    assign w_all[k] = (w_cnt == CNT_W'(IN_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_count <= w_fin_cnt;
      r_all   <= w_all;
      r_norm  <= w_norm;
      r_mode  <= w_fin_mode;
    end
  end

  assign out_count = r_count;
  assign out_all   = r_all;
  assign out_norm  = r_norm;
  assign out_mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_lzc_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lzc_pipe : self-checking bench for lzc_pipe over three configurations
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lzc_pipe;

  typedef struct {
    int          cnt;
    logic [31:0] norm;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // A: 32-bit, 1 lane, 2 stages
  logic        a_in_valid = 0, a_out_ready = 1, a_in_ready, a_out_valid;
  logic [31:0] a_in_data = '0, a_out_norm;
  logic [1:0]  a_in_mode = '0, a_out_mode;
  logic [5:0]  a_out_count;
  logic [0:0]  a_out_all;
  // B: 24-bit, 1 lane, 3 stages
  logic        b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid;
  logic [23:0] b_in_data = '0, b_out_norm;
  logic [1:0]  b_in_mode = '0, b_out_mode;
  logic [4:0]  b_out_count;
  logic [0:0]  b_out_all;
  // C: 32-bit, 2 lanes, 1 stage
  logic        c_in_valid = 0, c_out_ready = 1, c_in_ready, c_out_valid;
  logic [63:0] c_in_data = '0, c_out_norm;
  logic [1:0]  c_in_mode = '0, c_out_mode;
  logic [11:0] c_out_count;
  logic [1:0]  c_out_all;

  lzc_pipe #(.IN_WIDTH(32), .LANES(1), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_all(a_out_all), .out_norm(a_out_norm), .out_mode(a_out_mode));

  lzc_pipe #(.IN_WIDTH(24), .LANES(1), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_all(b_out_all), .out_norm(b_out_norm), .out_mode(b_out_mode));

  lzc_pipe #(.IN_WIDTH(32), .LANES(2), .STAGES(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_mode(c_in_mode), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
    .out_all(c_out_all), .out_norm(c_out_norm), .out_mode(c_out_mode));

  // Reference: walk the word bit by bit from the scan start and count the run of target bits.
  function automatic void model(input logic [31:0] d, input int w, input logic [1:0] m,
                                output int cnt, output logic [31:0] norm);
    logic [31:0] mask, dm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    dm   = d & mask;
    cnt  = 0;
    for (int k = 0; k < w; k++) begin
      if (dm[m[1] ? k : w - 1 - k] !== m[0]) break;
      cnt++;
    end
    norm = m[1] ? (dm >> cnt) : ((dm << cnt) & mask);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    int          k;
    d = $urandom;
    k = $urandom_range(0, 32);
    case ($urandom_range(0, 4))
      0:       return d;
      1:       return d >> k;
      2:       return ~(d >> k);
      3:       return d << k;
      default: return ~(d << k);
    endcase
  endfunction

  task automatic run_a(input logic [31:0] d, input logic [1:0] m, output logic [5:0] cnt,
                       output logic all, output logic [31:0] norm, output logic [1:0] mo, output int lat);
    @(negedge clk);
    a_in_data = d; a_in_mode = m; a_in_valid = 1'b1; a_out_ready = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      a_in_valid = 1'b0;
      lat++;
    end while (!a_out_valid && lat < 20);
    cnt = a_out_count; all = a_out_all[0]; norm = a_out_norm; mo = a_out_mode;
  endtask

  task automatic run_b(input logic [23:0] d, input logic [1:0] m, output logic [4:0] cnt,
                       output logic all, output logic [23:0] norm, output int lat);
    @(negedge clk);
    b_in_data = d; b_in_mode = m; b_in_valid = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      b_in_valid = 1'b0;
      lat++;
    end while (!b_out_valid && lat < 20);
    cnt = b_out_count; all = b_out_all[0]; norm = b_out_norm;
  endtask

  task automatic run_c(input logic [63:0] d, input logic [1:0] m, output int lat);
    @(negedge clk);
    c_in_data = d; c_in_mode = m; c_in_valid = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      c_in_valid = 1'b0;
      lat++;
    end while (!c_out_valid && lat < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a: got %b want 0", a_out_valid); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_b: got %b want 0", b_out_valid); end
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_c: got %b want 0", c_out_valid); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_known_words();
    logic [5:0] c; logic al; logic [31:0] nm; logic [1:0] mo; int lat, ecnt; logic [31:0] enorm;
    run_a(32'h0001_0000, 2'b00, c, al, nm, mo, lat);
    n_checks++; if (c !== 6'd15) begin n_fail++; $display("FAIL lz_count: got %0d want 15", c); end
    n_checks++; if (al !== 1'b0) begin n_fail++; $display("FAIL lz_all: got %b want 0", al); end
    n_checks++; if (nm !== 32'h8000_0000) begin n_fail++; $display("FAIL lz_norm: got %h want 80000000", nm); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lz_latency: got %0d want 2", lat); end
    run_a(32'h0000_0000, 2'b00, c, al, nm, mo, lat);
    n_checks++; if (c !== 6'd32) begin n_fail++; $display("FAIL zero_count: got %0d want 32", c); end
    n_checks++; if (al !== 1'b1) begin n_fail++; $display("FAIL zero_all: got %b want 1", al); end
    n_checks++; if (nm !== 32'h0) begin n_fail++; $display("FAIL zero_norm: got %h want 0", nm); end
    run_a(32'hFFFF_FFFF, 2'b01, c, al, nm, mo, lat);
    n_checks++; if (c !== 6'd32) begin n_fail++; $display("FAIL ones_count: got %0d want 32", c); end
    n_checks++; if (al !== 1'b1) begin n_fail++; $display("FAIL ones_all: got %b want 1", al); end
    n_checks++; if (mo !== 2'b01) begin n_fail++; $display("FAIL ones_mode: got %b want 01", mo); end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d; logic [1:0] m;
      d = rand_word(); m = 2'(i);
      model(d, 32, m, ecnt, enorm);
      run_a(d, m, c, al, nm, mo, lat);
      n_checks++; if (c !== 6'(ecnt)) begin n_fail++; $display("FAIL rand_count: in %h mode %b got %0d want %0d", d, m, c, ecnt); end
      n_checks++; if (nm !== enorm) begin n_fail++; $display("FAIL rand_norm: in %h mode %b got %h want %h", d, m, nm, enorm); end
      n_checks++; if (al !== (ecnt == 32)) begin n_fail++; $display("FAIL rand_all: in %h got %b want %b", d, al, ecnt == 32); end
      n_checks++; if (mo !== m) begin n_fail++; $display("FAIL rand_mode: got %b want %b", mo, m); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int sent = 0, got = 0, stalls = 0, extra = 0, idx;
    logic [31:0] d[8]; logic [1:0] md[8];
    logic prev_stall = 1'b0; logic [5:0] s_cnt; logic s_all; logic [31:0] s_norm; logic [1:0] s_mode;
    for (int i = 0; i < 8; i++) begin d[i] = rand_word(); md[i] = 2'($urandom); end
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      idx = (sent < 8) ? sent : 7;
      a_out_ready = !(cyc >= 3 && cyc <= 7);
      a_in_valid = (sent < 8); a_in_data = d[idx]; a_in_mode = md[idx];
      #1;
      if (prev_stall) begin
        n_checks++;
        if ({a_out_count, a_out_all, a_out_norm, a_out_mode} !== {s_cnt, s_all, s_norm, s_mode}) begin
          n_fail++; $display("FAIL b2b_stable: got %h/%h want %h/%h", a_out_count, a_out_norm, s_cnt, s_norm);
        end
      end
      if (a_out_valid && !a_out_ready) begin
        stalls++;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_full: got %b want 0", a_in_ready); end
      end
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) extra++;
        else begin
          e = q.pop_front(); got++;
          n_checks++;
          if (a_out_count !== 6'(e.cnt) || a_out_norm !== e.norm || a_out_mode !== e.mode) begin
            n_fail++; $display("FAIL b2b_order: beat %0d got %0d/%h want %0d/%h", got, a_out_count, a_out_norm, e.cnt, e.norm);
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        model(d[idx], 32, md[idx], e.cnt, e.norm); e.mode = md[idx];
        q.push_back(e); sent++;
      end
      prev_stall = a_out_valid & ~a_out_ready;
      s_cnt = a_out_count; s_all = a_out_all[0]; s_norm = a_out_norm; s_mode = a_out_mode;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (4) begin @(negedge clk); #1; if (a_out_valid) extra++; end
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_delivered: got %0d want 8", got); end
    n_checks++; if (stalls !== 5) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", stalls); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_beats: got %0d want 0", extra); end
  endtask

  task automatic test_random_stream();
    exp_t q[$]; exp_t e;
    int spurious = 0;
    logic prev_stall = 1'b0; logic [5:0] s_cnt; logic s_all; logic [31:0] s_norm; logic [1:0] s_mode;
    for (int cyc = 0; cyc < 400 && !(cyc >= 300 && q.size() == 0); cyc++) begin
      @(negedge clk);
      a_in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
      a_in_data   = rand_word();
      a_in_mode   = 2'($urandom);
      a_out_ready = (cyc >= 300) || ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_checks++;
        if ({a_out_count, a_out_all, a_out_norm, a_out_mode} !== {s_cnt, s_all, s_norm, s_mode}) begin
          n_fail++; $display("FAIL stream_stable: got %h/%h want %h/%h", a_out_count, a_out_norm, s_cnt, s_norm);
        end
      end
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) spurious++;
        else begin
          e = q.pop_front();
          n_checks++;
          if (a_out_count !== 6'(e.cnt) || a_out_norm !== e.norm || a_out_mode !== e.mode ||
              a_out_all[0] !== (e.cnt == 32)) begin
            n_fail++; $display("FAIL stream_data: got %0d/%h/%b want %0d/%h/%b", a_out_count, a_out_norm, a_out_mode, e.cnt, e.norm, e.mode);
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        model(a_in_data, 32, a_in_mode, e.cnt, e.norm); e.mode = a_in_mode;
        q.push_back(e);
      end
      prev_stall = a_out_valid & ~a_out_ready;
      s_cnt = a_out_count; s_all = a_out_all[0]; s_norm = a_out_norm; s_mode = a_out_mode;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL stream_drain: got %0d pending want 0", q.size()); end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL stream_spurious: got %0d want 0", spurious); end
  endtask

  task automatic test_midreset();
    logic [5:0] c; logic al; logic [31:0] nm; logic [1:0] mo; int lat, seen = 0;
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 2'b00; a_in_data = 32'h0000_00F0;
    @(negedge clk);
    a_in_data = 32'h0F00_0000;
    @(negedge clk);
    rst = 1'b1; a_in_data = 32'h0000_0001;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_hold: got %b want 0", a_in_ready); end
    rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (5) begin @(negedge clk); if (a_out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_ghost_beats: got %0d want 0", seen); end
    run_a(32'h0000_8000, 2'b00, c, al, nm, mo, lat);
    n_checks++; if (c !== 6'd16) begin n_fail++; $display("FAIL rst_next_count: got %0d want 16", c); end
    n_checks++; if (nm !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_next_norm: got %h want 80000000", nm); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rst_next_latency: got %0d want 2", lat); end
  endtask

  task automatic test_width24();
    logic [4:0] c; logic al; logic [23:0] nm; int lat, ecnt; logic [31:0] enorm;
    run_b(24'h00_0001, 2'b00, c, al, nm, lat);
    n_checks++; if (c !== 5'd23) begin n_fail++; $display("FAIL w24_lz_count: got %0d want 23", c); end
    n_checks++; if (nm !== 24'h80_0000) begin n_fail++; $display("FAIL w24_lz_norm: got %h want 800000", nm); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL w24_latency: got %0d want 3", lat); end
    run_b(24'h00_0001, 2'b10, c, al, nm, lat);
    n_checks++; if (c !== 5'd0) begin n_fail++; $display("FAIL w24_tz_count: got %0d want 0", c); end
    n_checks++; if (nm !== 24'h00_0001) begin n_fail++; $display("FAIL w24_tz_norm: got %h want 000001", nm); end
    run_b(24'hFF_FFFF, 2'b01, c, al, nm, lat);
    n_checks++; if (c !== 5'd24 || al !== 1'b1 || nm !== 24'h0) begin n_fail++; $display("FAIL w24_all_ones: got %0d/%b/%h want 24/1/0", c, al, nm); end
    for (int i = 0; i < 16; i++) begin
      logic [23:0] d; logic [1:0] m;
      d = 24'(rand_word()); m = 2'(i);
      model({8'h0, d}, 24, m, ecnt, enorm);
      run_b(d, m, c, al, nm, lat);
      n_checks++;
      if (c !== 5'(ecnt) || nm !== enorm[23:0] || al !== (ecnt == 24)) begin
        n_fail++; $display("FAIL w24_rand: in %h mode %b got %0d/%h want %0d/%h", d, m, c, nm, ecnt, enorm[23:0]);
      end
    end
  endtask

  task automatic test_lanes2();
    int lat, ecnt; logic [31:0] enorm;
    run_c({32'h8000_0000, 32'h0000_00FF}, 2'b11, lat);
    n_checks++; if (c_out_count !== {6'd0, 6'd8}) begin n_fail++; $display("FAIL lanes_counts: got %h want %h", c_out_count, {6'd0, 6'd8}); end
    n_checks++; if (c_out_norm[31:0] !== 32'h0) begin n_fail++; $display("FAIL lanes_norm0: got %h want 0", c_out_norm[31:0]); end
    n_checks++; if (c_out_norm[63:32] !== 32'h8000_0000) begin n_fail++; $display("FAIL lanes_norm1: got %h want 80000000", c_out_norm[63:32]); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lanes_latency: got %0d want 1", lat); end
    for (int i = 0; i < 16; i++) begin
      logic [63:0] d; logic [1:0] m;
      d = {rand_word(), rand_word()}; m = 2'(i);
      run_c(d, m, lat);
      for (int k = 0; k < 2; k++) begin
        model(d[k*32 +: 32], 32, m, ecnt, enorm);
        n_checks++;
        if (c_out_count[k*6 +: 6] !== 6'(ecnt) || c_out_norm[k*32 +: 32] !== enorm || c_out_all[k] !== (ecnt == 32)) begin
          n_fail++; $display("FAIL lanes_rand: lane %0d in %h mode %b got %0d/%h want %0d/%h",
                             k, d[k*32 +: 32], m, c_out_count[k*6 +: 6], c_out_norm[k*32 +: 32], ecnt, enorm);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_words();
    test_back_to_back();
    test_random_stream();
    test_midreset();
    test_width24();
    test_lanes2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
